demux1_16_deser: RTL and testbench

DEMUX1_16_DESER -- requirements
Module: demux1_16_deser

---
 rtl/demux1_16_deser_pkg.sv | 11 +
 rtl/idx_cnt4.sv | 25 ++
 rtl/demux1_16_deser.sv | 116 +++++++++++
 tb/tb_demux1_16_deser.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux1_16_deser_pkg.sv
// Shared widths and FSM state encodings for the 1:16 serial-to-parallel deserializer.
package demux1_16_deser_pkg;
  localparam int WORD_W = 16;
  localparam int IDX_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;
endpackage

// File: rtl/idx_cnt4.sv
// 4-bit up/down index counter with synchronous load and a terminal-count flag.
module idx_cnt4
  import demux1_16_deser_pkg::*;
#(
  parameter logic [IDX_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [IDX_W-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [IDX_W-1:0] cnt,
  output logic             tc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= RST_VAL;
    else if (load) cnt <= load_val;
    else if (en)   cnt <= up ? cnt + 4'd1 : cnt - 4'd1;
  end

  assign tc = up ? (cnt == 4'hF) : (cnt == 4'h0);

endmodule

// File: rtl/demux1_16_deser.sv
// Collects 16 handshaked serial bits into a word and hands it to a valid/ready output register.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | waiting for start, din not accepted
//   ST_COLLECT | accepting bits into shreg[sel]
//   ST_HOLD    | full word in shreg, waiting for the output register to free
module demux1_16_deser
  import demux1_16_deser_pkg::*;
#(
  parameter int LSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [IDX_W-1:0]  sel,
  output logic [WORD_W-1:0] op,
  output logic              op_valid,
  input  logic              op_ready,
  output logic              busy
);

  localparam logic             COUNT_UP  = (LSB_FIRST != 0);
  localparam logic [IDX_W-1:0] START_IDX = COUNT_UP ? 4'd0 : 4'd15;

  state_t              state, state_next;
  logic [WORD_W-1:0]   shreg, word_next;
  logic                cnt_load, cnt_en, bit_we, xfer, last_idx, out_free;

  // Wrap-around after the final index lands the counter back on START_IDX.
  idx_cnt4 #(.RST_VAL(START_IDX)) u_idx (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (START_IDX),
    .en       (cnt_en),
    .up       (COUNT_UP),
    .cnt      (sel),
    .tc       (last_idx)
  );

  assign out_free  = !op_valid || op_ready;
  assign din_ready = (state == ST_COLLECT);
  assign busy      = (state != ST_IDLE);

  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    bit_we     = 1'b0;
    xfer       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_COLLECT;
          cnt_load   = 1'b1;
        end
      end
      ST_COLLECT: begin
        if (start) begin
          cnt_load = 1'b1;
        end else if (din_valid) begin
          bit_we = 1'b1;
          cnt_en = 1'b1;
          if (last_idx) begin
            if (out_free) begin
              xfer       = 1'b1;
              state_next = ST_IDLE;
            end else begin
              state_next = ST_HOLD;
            end
          end
        end
      end
      ST_HOLD: begin
        if (out_free) begin
          xfer       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    word_next = shreg;
    if (bit_we) word_next[sel] = din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      shreg <= '0;
    end else begin
      state <= state_next;
      shreg <= word_next;
    end
  end

  // A transfer on the same edge as a consume keeps op_valid high with the new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op       <= '0;
      op_valid <= 1'b0;
    end else if (xfer) begin
      op       <= word_next;
      op_valid <= 1'b1;
    end else if (op_ready) begin
      op_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_demux1_16_deser.sv
// Drives an MSB-first and an LSB-first instance from shared stimulus against a frame-level model.
module tb_demux1_16_deser;

  logic clk = 1'b0;
  logic rst, start, din, din_valid, op_ready;

  logic        rdy_m, ov_m, busy_m, rdy_l, ov_l, busy_l;
  logic [3:0]  sel_m, sel_l;
  logic [15:0] op_m, op_l;

  int n_chk  = 0;
  int n_pass = 0;

  // model: 0 idle, 1 collecting, 2 waiting with a full frame
  int          mode = 0;
  bit          bits[$];
  logic [15:0] exp_op_m = '0, exp_op_l = '0;
  logic        exp_ov = 1'b0;

  always #5 clk = ~clk;

  demux1_16_deser #(.LSB_FIRST(0)) u_msb (
    .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
    .din_ready(rdy_m), .sel(sel_m), .op(op_m), .op_valid(ov_m),
    .op_ready(op_ready), .busy(busy_m)
  );

  demux1_16_deser #(.LSB_FIRST(1)) u_lsb (
    .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
    .din_ready(rdy_l), .sel(sel_l), .op(op_l), .op_valid(ov_l),
    .op_ready(op_ready), .busy(busy_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] pack(input bit lsb);
    logic [15:0] w = '0;
    for (int i = 0; i < bits.size(); i++) begin
      if (lsb) w[i] = bits[i];
      else     w[15-i] = bits[i];
    end
    return w;
  endfunction

  task automatic model_reset();
    mode = 0;
    bits.delete();
    exp_op_m = '0;
    exp_op_l = '0;
    exp_ov   = 1'b0;
  endtask

  task automatic check_all();
    logic [3:0] es_m, es_l;
    es_m = (mode == 1) ? 4'(15 - bits.size()) : 4'd15;
    es_l = (mode == 1) ? 4'(bits.size())      : 4'd0;
    chk("din_ready_m", rdy_m, mode == 1);
    chk("din_ready_l", rdy_l, mode == 1);
    chk("busy_m", busy_m, mode != 0);
    chk("busy_l", busy_l, mode != 0);
    chk("sel_m", sel_m, es_m);
    chk("sel_l", sel_l, es_l);
    chk("op_valid_m", ov_m, exp_ov);
    chk("op_valid_l", ov_l, exp_ov);
    chk("op_m", op_m, exp_op_m);
    chk("op_l", op_l, exp_op_l);
  endtask

  task automatic model_update();
    bit free, xfer;
    free = !exp_ov || op_ready;
    xfer = 1'b0;
    case (mode)
      0: if (start) begin mode = 1; bits.delete(); end
      1: begin
        if (start) bits.delete();
        else if (din_valid) begin
          bits.push_back(din);
          if (bits.size() == 16) begin
            if (free) xfer = 1'b1;
            else      mode = 2;
          end
        end
      end
      default: if (free) xfer = 1'b1;
    endcase
    if (xfer) begin
      exp_op_m = pack(1'b0);
      exp_op_l = pack(1'b1);
      exp_ov   = 1'b1;
      mode     = 0;
      bits.delete();
    end else if (exp_ov && op_ready) begin
      exp_ov = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    model_update();
    @(posedge clk);
    #1;
  endtask

  // word bits sent MSB-first unless lsb_order; nbits < 16 leaves a partial frame
  task automatic send_frame(input logic [15:0] w, input bit lsb_order, input int max_gap,
                            input bit with_start, input int nbits);
    if (with_start) begin
      start = 1'b1; din_valid = 1'($urandom); din = 1'($urandom);
      step();
      start = 1'b0;
    end
    for (int i = 0; i < nbits; i++) begin
      for (int k = $urandom_range(0, max_gap); k > 0; k--) begin
        din_valid = 1'b0; din = 1'($urandom);
        step();
      end
      din_valid = 1'b1;
      din = lsb_order ? w[i] : w[15-i];
      step();
    end
    din_valid = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_op"}, {op_m, op_l}, 32'h0);
    chk({tag, "_ov"}, {ov_m, ov_l}, 2'b00);
    chk({tag, "_rdy"}, {rdy_m, rdy_l}, 2'b00);
    chk({tag, "_busy"}, {busy_m, busy_l}, 2'b00);
    chk({tag, "_sel"}, {sel_m, sel_l}, 8'hF0);
    model_reset();
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; din = 1'b0; din_valid = 1'b0; op_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {op_m, ov_m, rdy_m, busy_m, sel_m}, {16'h0, 3'b000, 4'hF});
    chk("reset_state_l", {op_l, ov_l, rdy_l, busy_l, sel_l}, {16'h0, 3'b000, 4'h0});
    rst = 1'b0;
    step();

    // back-to-back A5C3, MSB-first order
    send_frame(16'hA5C3, 1'b0, 0, 1'b1, 16);
    chk("a5c3_latency", {ov_m, ov_l}, 2'b11);
    chk("pin_a5c3_m", exp_op_m, 16'hA5C3);
    chk("pin_a5c3_l", exp_op_l, 16'hC3A5);
    chk("a5c3_op_m", op_m, 16'hA5C3);
    chk("a5c3_idle", busy_m, 1'b0);
    step();

    // 8001 sent LSB-first with gaps
    send_frame(16'h8001, 1'b1, 3, 1'b1, 16);
    step();
    chk("pin_8001_l", exp_op_l, 16'h8001);
    chk("8001_op_l", op_l, 16'h8001);

    // held frame, second frame stalls in HOLD, start ignored there
    op_ready = 1'b0;
    send_frame(16'h0F0F, 1'b0, 1, 1'b1, 16);
    send_frame(16'hF00F, 1'b0, 1, 1'b1, 16);
    chk("hold_busy", {busy_m, rdy_m}, 2'b10);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    chk("hold_op_m", op_m, 16'h0F0F);
    chk("hold_op_l", op_l, 16'hF0F0);
    op_ready = 1'b1;
    step();
    chk("hold_release_m", op_m, 16'hF00F);
    chk("pin_f00f_m", exp_op_m, 16'hF00F);
    step();

    // abort after 7 bits with a coincident handshake
    send_frame(16'hFFFF, 1'b0, 1, 1'b1, 7);
    start = 1'b1; din_valid = 1'b1; din = 1'b1;
    step();
    start = 1'b0;
    send_frame(16'h1234, 1'b0, 1, 1'b0, 16);
    step();
    chk("abort_op_m", op_m, 16'h1234);
    chk("abort_op_l", op_l, 16'h2C48);
    chk("pin_1234_l", exp_op_l, 16'h2C48);

    // async reset mid-frame, then in HOLD
    send_frame(16'h0000, 1'b0, 0, 1'b1, 6);
    chk("mid_sel9", sel_m, 4'd9);
    async_reset("rst_mid");
    step();
    op_ready = 1'b0;
    send_frame(16'h5555, 1'b0, 0, 1'b1, 16);
    send_frame(16'h3333, 1'b0, 0, 1'b1, 16);
    chk("hold_before_rst", busy_m, 1'b1);
    async_reset("rst_hold");
    op_ready = 1'b1;
    step();
    send_frame(16'hFFFF, 1'b0, 2, 1'b1, 16);
    step();
    chk("ffff_op_m", op_m, 16'hFFFF);
    chk("ffff_op_l", op_l, 16'hFFFF);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      start     = ($urandom_range(0, 24) == 0);
      din_valid = ($urandom_range(0, 2) != 0);
      din       = 1'($urandom);
      op_ready  = ($urandom_range(0, 3) != 0);
      step();
    end
    start = 1'b0; din_valid = 1'b0; op_ready = 1'b1;
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
